bcd_countdown_timer: RTL and testbench

Multi-digit packed-BCD down-counter with load, start/pause control and expiry detection. It is the counting-down counterpart to the team's single-digit BCD up-counter. Counting advances on a single-cycle `tick` strobe from a shared prescaler. The block drives countdown displays and timeout events in the same timer/counter subsystem.

---
 rtl/bcd_countdown_timer.sv | 181 ++++++++++++++++++
 tb/tb_bcd_countdown_timer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown_timer.sv
// Packed-BCD countdown timer with load, start/pause control and expiry detection.
// Optional auto-reload mode is enabled by defining BCD_TIMER_AUTO_RELOAD_EN.
module bcd_countdown_timer #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                start,
  input  logic                pause,
  input  logic                tick,
  output logic [4*DIGITS-1:0] count,
  output logic                running,
  output logic                expired,
  output logic                done_pulse,
  output logic                load_err
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  function automatic logic bcd_valid(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      ok = ok & (v[4*i +: 4] <= 4'd9);
    end
    return ok;
  endfunction

  // Borrow ripples upward only through digits that were zero before the tick.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    logic [3:0]   d;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (borrow) begin
        if (d == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = d - 4'd1;
          borrow      = 1'b0;
        end
      end else begin
        r[4*i +: 4] = d;
      end
    end
    return r;
  endfunction

  state_t         state_q, state_d;
  logic [W-1:0]   count_q, count_d;
  logic           running_q, running_d;
  logic           expired_q, expired_d;
  logic           done_q, done_d;
  logic           load_err_q, load_err_d;
  logic           load_ok_s;
  logic           done_evt_s;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
  logic [W-1:0]   reload_q, reload_d;
`endif

  // Next-state, next-count and registered-output computation.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    load_err_d = 1'b0;
    done_evt_s = 1'b0;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
    reload_d   = reload_q;
`endif
    load_ok_s  = load & bcd_valid(load_val);

    if (load_ok_s) begin
      count_d = load_val;
      state_d = ST_IDLE;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
      reload_d = load_val;
`endif
    end else begin
      // A rejected load still lets pause/start/tick act this cycle.
      load_err_d = load;
      case (state_q)
        ST_IDLE: begin
          if (!pause && start) begin
            if (count_q != '0) begin
              state_d = ST_RUN;
            end else begin
              state_d    = ST_EXPIRED;
              done_evt_s = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSED;
          end else if (tick) begin
            if (count_q == CNT_ONE) begin
`ifdef BCD_TIMER_AUTO_RELOAD_EN
              count_d = reload_q;
`else
              count_d = '0;
              state_d = ST_EXPIRED;
`endif
              done_evt_s = 1'b1;
            end else if (count_q != '0) begin
              count_d = bcd_dec(count_q);
            end else begin
              count_d = count_q;
            end
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_PAUSED: begin
          if (!pause && start) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_PAUSED;
          end
        end
        ST_EXPIRED: begin
          state_d = ST_EXPIRED;
        end
        default: begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      endcase
    end

    done_d    = done_evt_s & ~done_q;
    running_d = (state_d == ST_RUN);
    expired_d = (state_d == ST_EXPIRED);
  end

  // State, count and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      running_q  <= 1'b0;
      expired_q  <= 1'b0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
      reload_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      running_q  <= running_d;
      expired_q  <= expired_d;
      done_q     <= done_d;
      load_err_q <= load_err_d;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
      reload_q   <= reload_d;
`endif
    end
  end

  assign count      = count_q;
  assign running    = running_q;
  assign expired    = expired_q;
  assign done_pulse = done_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed self-checking bench for bcd_countdown_timer (DIGITS=4).
module tb_bcd_countdown_timer;

  logic        clk;
  logic        reset_n;
  logic        load;
  logic [15:0] load_val;
  logic        start;
  logic        pause;
  logic        tick;
  logic [15:0] count;
  logic        running;
  logic        expired;
  logic        done_pulse;
  logic        load_err;

  int n_checks;
  int n_fail;

  bcd_countdown_timer #(.DIGITS(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .load_val   (load_val),
    .start      (start),
    .pause      (pause),
    .tick       (tick),
    .count      (count),
    .running    (running),
    .expired    (expired),
    .done_pulse (done_pulse),
    .load_err   (load_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs starting at a falling edge; outputs are then
  // observed at the next falling edge, half a cycle after the sampling edge.
  task automatic step(input logic l, input logic [15:0] lv, input logic s,
                      input logic p, input logic t);
    load = l; load_val = lv; start = s; pause = p; tick = t;
    @(negedge clk);
    load = 1'b0; load_val = 16'h0000; start = 1'b0; pause = 1'b0; tick = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    load = 1'b0; load_val = 16'h0000; start = 1'b0; pause = 1'b0; tick = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (count !== 16'h0000) begin n_fail++; $display("FAIL reset_count: got %h expected 0000", count); end
    n_checks++; if ({running, expired, done_pulse, load_err} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {running, expired, done_pulse, load_err}); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_countdown;
    step(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
    n_checks++; if (count !== 16'h0003) begin n_fail++; $display("FAIL cd_load: got %h expected 0003", count); end
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL cd_running: got %b expected 1", running); end
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    n_checks++; if (count !== 16'h0002) begin n_fail++; $display("FAIL cd_tick1: got %h expected 0002", count); end
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    n_checks++; if (count !== 16'h0001) begin n_fail++; $display("FAIL cd_tick2: got %h expected 0001", count); end
    n_checks++; if (done_pulse !== 1'b0) begin n_fail++; $display("FAIL cd_early_done: got %b expected 0", done_pulse); end
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    n_checks++; if (count !== 16'h0000) begin n_fail++; $display("FAIL cd_tick3: got %h expected 0000", count); end
    n_checks++; if ({done_pulse, expired, running} !== 3'b110) begin n_fail++; $display("FAIL cd_expire_flags: got %b expected 110", {done_pulse, expired, running}); end
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    n_checks++; if (done_pulse !== 1'b0) begin n_fail++; $display("FAIL cd_done_width: got %b expected 0", done_pulse); end
    n_checks++; if ({count, expired} !== {16'h0000, 1'b1}) begin n_fail++; $display("FAIL cd_hold_zero: got %h/%b expected 0000/1", count, expired); end
  endtask

  task automatic test_borrow;
    step(1'b1, 16'h1000, 1'b0, 1'b0, 1'b0);
    n_checks++; if (expired !== 1'b0) begin n_fail++; $display("FAIL br_leave_expired: got %b expected 0", expired); end
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    n_checks++; if (count !== 16'h0999) begin n_fail++; $display("FAIL br_ripple: got %h expected 0999", count); end
    n_checks++; if ({done_pulse, running} !== 2'b01) begin n_fail++; $display("FAIL br_flags: got %b expected 01", {done_pulse, running}); end
  endtask

  task automatic test_load_err;
    // Running at 0999 from the previous scenario.
    step(1'b1, 16'h0A12, 1'b0, 1'b0, 1'b0);
    n_checks++; if (load_err !== 1'b1) begin n_fail++; $display("FAIL le_pulse: got %b expected 1", load_err); end
    n_checks++; if ({count, running} !== {16'h0999, 1'b1}) begin n_fail++; $display("FAIL le_unchanged: got %h/%b expected 0999/1", count, running); end
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    n_checks++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL le_width: got %b expected 0", load_err); end
    step(1'b1, 16'h00F0, 1'b0, 1'b0, 1'b1);
    n_checks++; if ({count, load_err} !== {16'h0998, 1'b1}) begin n_fail++; $display("FAIL le_tick_evaluated: got %h/%b expected 0998/1", count, load_err); end
  endtask

  task automatic test_pause;
    step(1'b1, 16'h0050, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    n_checks++; if ({count, running, expired} !== {16'h0050, 1'b0, 1'b0}) begin n_fail++; $display("FAIL pa_pause_tick: got %h/%b/%b expected 0050/0/0", count, running, expired); end
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    n_checks++; if (count !== 16'h0050) begin n_fail++; $display("FAIL pa_hold: got %h expected 0050", count); end
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    n_checks++; if ({count, running} !== {16'h0050, 1'b1}) begin n_fail++; $display("FAIL pa_resume: got %h/%b expected 0050/1", count, running); end
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    n_checks++; if (count !== 16'h0049) begin n_fail++; $display("FAIL pa_tick_after: got %h expected 0049", count); end
  endtask

  task automatic test_load_tick;
    step(1'b1, 16'h0020, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'h0007, 1'b0, 1'b0, 1'b1);
    n_checks++; if ({count, running} !== {16'h0007, 1'b0}) begin n_fail++; $display("FAIL lt_load_wins: got %h/%b expected 0007/0", count, running); end
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    n_checks++; if (count !== 16'h0007) begin n_fail++; $display("FAIL lt_idle_tick: got %h expected 0007", count); end
  endtask

  task automatic test_start_edges;
    step(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    n_checks++; if ({count, running} !== {16'h0005, 1'b1}) begin n_fail++; $display("FAIL se_start_tick: got %h/%b expected 0005/1", count, running); end
    step(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    n_checks++; if ({done_pulse, expired, running} !== 3'b110) begin n_fail++; $display("FAIL se_start_zero: got %b expected 110", {done_pulse, expired, running}); end
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    n_checks++; if ({count, done_pulse, expired} !== {16'h0000, 1'b0, 1'b1}) begin n_fail++; $display("FAIL se_expired_ignore: got %h/%b/%b expected 0000/0/1", count, done_pulse, expired); end
  endtask

  task automatic test_async_reset;
    step(1'b1, 16'h0042, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    n_checks++; if (count !== 16'h0041) begin n_fail++; $display("FAIL ar_precount: got %h expected 0041", count); end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++; if ({count, running, expired, done_pulse, load_err} !== 20'h00000) begin n_fail++; $display("FAIL ar_immediate: got %h/%b expected 0000/0000", count, {running, expired, done_pulse, load_err}); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

`ifdef BCD_TIMER_AUTO_RELOAD_EN
  task automatic test_auto_reload;
    logic [15:0] exp_cnt [6];
    exp_cnt = '{16'h0001, 16'h0002, 16'h0001, 16'h0002, 16'h0001, 16'h0002};
    step(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
      n_checks++; if ({count, done_pulse, running} !== {exp_cnt[i], (i % 2 == 1), 1'b1}) begin n_fail++; $display("FAIL rl_tick%0d: got %h/%b/%b expected %h/%b/1", i + 1, count, done_pulse, running, exp_cnt[i], (i % 2 == 1)); end
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_countdown();
    test_borrow();
    test_load_err();
    test_pause();
    test_load_tick();
    test_start_edges();
    test_async_reset();
`ifdef BCD_TIMER_AUTO_RELOAD_EN
    test_auto_reload();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
